fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that sits between the memory controller and the instruction queue. It holds the fetch PC and issues one 32-bit word request at a time to the memory controller. It pushes each returned instruction and its PC into the queue, and stalls while the queue reports full. On a branch or jump redirect it switches to the new PC and discards any response still in flight, which keeps the queue free of wrong-path instructions.

---
 rtl/cpu_defs.sv | 21 ++
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl_chk.sv | 18 +
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared CPU front-end definitions: datapath widths, fetch FSM encodings and
// the reset fetch address.
package cpu_defs;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    // Fetches are whole words, so redirect targets drop their byte offset
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: redirect input, memory request/response and instruction
// queue write port. master = fetch sequencer, slave = its environment.
interface fetch_ctrl_if;
    import cpu_defs::*;

    logic              redirect_i;
    logic [XLEN-1:0]   redirect_pc_i;
    logic              mem_req_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic              mem_done_i;
    logic [INST_W-1:0] mem_data_i;
    logic              iq_full_i;
    logic              iq_we_o;
    logic [INST_W-1:0] iq_inst_o;
    logic [XLEN-1:0]   iq_pc_o;

    modport master (
        input  redirect_i, redirect_pc_i, mem_done_i, mem_data_i, iq_full_i,
        output mem_req_o, mem_addr_o, iq_we_o, iq_inst_o, iq_pc_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, mem_done_i, mem_data_i, iq_full_i,
        input  mem_req_o, mem_addr_o, iq_we_o, iq_inst_o, iq_pc_o
    );

endinterface

// File: rtl/fetch_ctrl_chk.sv
// Protocol checker for the fetch sequencer: a memory response may only arrive
// while a request is outstanding.
module fetch_ctrl_chk
    import cpu_defs::*;
(
    input logic         clk,
    input logic         rst,
    input logic         i_rdy,
    input fetch_state_e i_state,
    input logic         i_mem_done
);

    a_no_done_in_idle: assert property (
        @(posedge clk) disable iff (rst)
        (i_rdy && (i_state == FS_IDLE)) |-> !i_mem_done
    );

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding word request at a time, pushes
// returned instructions with their PC into the queue, drops wrong-path data.
module fetch_ctrl
    import cpu_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    fetch_ctrl_if.master bus
);

    fetch_state_e      r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_mem_req;
    logic [XLEN-1:0]   r_mem_addr;
    logic              r_iq_we;
    logic [INST_W-1:0] r_iq_inst;
    logic [XLEN-1:0]   r_iq_pc;

    fetch_state_e      w_state_nxt;
    logic [XLEN-1:0]   w_pc_nxt;
    logic              w_mem_req_nxt;
    logic [XLEN-1:0]   w_mem_addr_nxt;
    logic              w_iq_we_nxt;
    logic [INST_W-1:0] w_iq_inst_nxt;
    logic [XLEN-1:0]   w_iq_pc_nxt;
    logic [XLEN-1:0]   w_target;

    assign w_target = word_align(bus.redirect_pc_i);

    // State and output registers; rdy=0 freezes everything, reset still wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FS_IDLE;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0000_0000;
            r_iq_we    <= 1'b0;
            r_iq_inst  <= 32'h0000_0000;
            r_iq_pc    <= 32'h0000_0000;
        end else if (rdy) begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_iq_we    <= w_iq_we_nxt;
            r_iq_inst  <= w_iq_inst_nxt;
            r_iq_pc    <= w_iq_pc_nxt;
        end
    end

    // Next-state logic; pulses default low so they last exactly one enabled cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_mem_req_nxt  = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_iq_we_nxt    = 1'b0;
        w_iq_inst_nxt  = r_iq_inst;
        w_iq_pc_nxt    = r_iq_pc;
        case (r_state)
            FS_IDLE: begin
                if (bus.redirect_i) begin
                    w_pc_nxt = w_target;
                end else if (!bus.iq_full_i) begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = r_pc;
                    w_state_nxt    = FS_WAIT;
                end else begin
                    w_state_nxt = FS_IDLE;
                end
            end
            FS_WAIT: begin
                if (bus.mem_done_i) begin
                    w_state_nxt = FS_IDLE;
                    if (bus.redirect_i) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_iq_we_nxt   = 1'b1;
                        w_iq_inst_nxt = bus.mem_data_i;
                        w_iq_pc_nxt   = r_pc;
                        w_pc_nxt      = r_pc + 32'd4;
                    end
                end else if (bus.redirect_i) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = FS_DROP;
                end else begin
                    w_state_nxt = FS_WAIT;
                end
            end
            FS_DROP: begin
                // Wrong-path response is swallowed; later redirects overwrite earlier ones
                if (bus.redirect_i) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_pc_nxt = r_pc;
                end
                if (bus.mem_done_i) begin
                    w_state_nxt = FS_IDLE;
                end else begin
                    w_state_nxt = FS_DROP;
                end
            end
            default: begin
                w_state_nxt = FS_IDLE;
            end
        endcase
    end

    assign bus.mem_req_o  = r_mem_req;
    assign bus.mem_addr_o = r_mem_addr;
    assign bus.iq_we_o    = r_iq_we;
    assign bus.iq_inst_o  = r_iq_inst;
    assign bus.iq_pc_o    = r_iq_pc;

    fetch_ctrl_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .i_rdy      (rdy),
        .i_state    (r_state),
        .i_mem_done (bus.mem_done_i)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with a frozen-by-rdy memory model,
// then randomized traffic against a transaction-level fetch-stream model.
module tb_fetch_ctrl;
    import cpu_defs::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          mem_cnt = 0;
    int          mem_lat = 3;
    int          last_done_cyc = -100;
    bit          fixed_data = 1'b1;
    logic [31:0] mem_addr_q = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return fixed_data ? 32'h0000_0013 : ((a ^ 32'h5A5A_1234) + 32'd7);
    endfunction

    // One clock; memory controller only advances when the edge was enabled
    task automatic step();
        logic was_rdy;
        was_rdy = rdy;
        @(posedge clk);
        #1;
        cyc++;
        if (was_rdy) begin
            bus.mem_done_i = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.mem_done_i = 1'b1;
                    bus.mem_data_i = mem_word(mem_addr_q);
                    last_done_cyc  = cyc;
                end
            end
            if (bus.mem_req_o === 1'b1) begin
                mem_cnt    = mem_lat;
                mem_addr_q = bus.mem_addr_o;
            end
        end
    endtask

    task automatic do_reset(input logic full);
        rst = 1'b1;
        rdy = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.iq_full_i     = full;
        bus.mem_done_i    = 1'b0;
        bus.mem_data_i    = 32'h0;
        mem_cnt = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic redirect_idle(input logic [31:0] a);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = a;
        step();
        bus.redirect_i = 1'b0;
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step();
            if (bus.mem_req_o === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_we(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step();
            if (bus.iq_we_o === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b0;
        bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0; bus.iq_full_i = 1'b0;
        bus.mem_done_i = 1'b0; bus.mem_data_i = 32'h0;
        mem_cnt = 0;
        for (int i = 0; i < 3; i++) step();
        total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b exp 0", bus.mem_req_o); end
        total++; if (bus.mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h exp 0", bus.mem_addr_o); end
        total++; if (bus.iq_we_o !== 1'b0) begin bad++; $display("FAIL reset_we: got %b exp 0", bus.iq_we_o); end
        total++; if (bus.iq_inst_o !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h exp 0", bus.iq_inst_o); end
        total++; if (bus.iq_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h exp 0", bus.iq_pc_o); end
        rdy = 1'b1;
        step();
        total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_hold_req: got %b exp 0", bus.mem_req_o); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        int nreq, nwe, c0;
        logic [31:0] ea, ew;
        fixed_data = 1'b1;
        mem_lat = 3;
        do_reset(1'b0);
        nreq = 0; nwe = 0; ea = 32'h0; ew = 32'h0; c0 = cyc; last_done_cyc = -100;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.mem_req_o === 1'b1) begin
                total++;
                if (bus.mem_addr_o !== ea || (nreq == 0 && cyc != c0 + 1) || (nreq > 0 && cyc != last_done_cyc + 2)) begin
                    bad++; $display("FAIL seq_req: got addr %h at cyc %0d exp addr %h (done cyc %0d)", bus.mem_addr_o, cyc, ea, last_done_cyc);
                end
                ea = ea + 32'd4; nreq++;
            end
            if (bus.iq_we_o === 1'b1) begin
                total++;
                if (bus.iq_pc_o !== ew || bus.iq_inst_o !== 32'h13 || cyc != last_done_cyc + 1) begin
                    bad++; $display("FAIL seq_we: got (%h,%h) at cyc %0d exp (%h,00000013) at %0d", bus.iq_pc_o, bus.iq_inst_o, cyc, ew, last_done_cyc + 1);
                end
                ew = ew + 32'd4; nwe++;
            end
        end
        total++;
        if (nreq != 4 || nwe != 4) begin bad++; $display("FAIL seq_count: got req=%0d we=%0d exp 4/4", nreq, nwe); end
    endtask

    task automatic test_full();
        bit ok;
        fixed_data = 1'b0;
        mem_lat = 2;
        do_reset(1'b1);
        redirect_idle(32'h0ABC_0012);
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL full_hold: got req %b exp 0 (cycle %0d)", bus.mem_req_o, i); end
        end
        bus.iq_full_i = 1'b0;
        step();
        total++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0ABC_0010) begin
            bad++; $display("FAIL full_release: got req %b addr %h exp 1 0abc0010", bus.mem_req_o, bus.mem_addr_o);
        end
        bus.iq_full_i = 1'b1;
        wait_we(6, ok);
        total++;
        if (!ok || bus.iq_pc_o !== 32'h0ABC_0010 || bus.iq_inst_o !== mem_word(32'h0ABC_0010)) begin
            bad++; $display("FAIL full_write: got ok %b (%h,%h) exp (0abc0010,%h)", ok, bus.iq_pc_o, bus.iq_inst_o, mem_word(32'h0ABC_0010));
        end
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL full_after_write: got req %b exp 0", bus.mem_req_o); end
        end
    endtask

    task automatic test_redirect_drop();
        fixed_data = 1'b0;
        mem_lat = 4;
        do_reset(1'b1);
        redirect_idle(32'h0000_0010);
        bus.iq_full_i = 1'b0;
        step();
        total++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h10) begin bad++; $display("FAIL drop_first_req: got %b %h exp 1 00000010", bus.mem_req_o, bus.mem_addr_o); end
        step();
        step();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0200;
        for (int k = 1; k <= 4; k++) begin
            step();
            bus.redirect_i = 1'b0;
            total++;
            if (bus.iq_we_o !== 1'b0 || bus.mem_req_o !== (k == 4)) begin
                bad++; $display("FAIL drop_window: k=%0d got we %b req %b exp we 0 req %b", k, bus.iq_we_o, bus.mem_req_o, (k == 4));
            end
        end
        total++; if (bus.mem_addr_o !== 32'h200) begin bad++; $display("FAIL drop_new_addr: got %h exp 00000200", bus.mem_addr_o); end
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0300;
        step();
        bus.redirect_pc_i = 32'h0000_0404;
        for (int k = 2; k <= 6; k++) begin
            step();
            bus.redirect_i = 1'b0;
            total++;
            if (bus.iq_we_o !== 1'b0 || bus.mem_req_o !== (k == 6)) begin
                bad++; $display("FAIL drop_multi: k=%0d got we %b req %b exp we 0 req %b", k, bus.iq_we_o, bus.mem_req_o, (k == 6));
            end
        end
        total++; if (bus.mem_addr_o !== 32'h404) begin bad++; $display("FAIL drop_last_wins: got %h exp 00000404", bus.mem_addr_o); end
    endtask

    task automatic test_redirect_done();
        fixed_data = 1'b0;
        mem_lat = 3;
        do_reset(1'b1);
        redirect_idle(32'h0000_7000);
        bus.iq_full_i = 1'b0;
        step();
        step(); step(); step();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_1003;
        step();
        bus.redirect_i = 1'b0;
        total++; if (bus.iq_we_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL rdone_nowrite: got we %b req %b exp 0 0", bus.iq_we_o, bus.mem_req_o); end
        step();
        total++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h1000 || bus.iq_we_o !== 1'b0) begin
            bad++; $display("FAIL rdone_req: got req %b addr %h we %b exp 1 00001000 0", bus.mem_req_o, bus.mem_addr_o, bus.iq_we_o);
        end
    endtask

    task automatic test_rdy_freeze();
        logic [31:0] d;
        fixed_data = 1'b0;
        mem_lat = 3;
        d = mem_word(32'h40);
        do_reset(1'b1);
        redirect_idle(32'h0000_0040);
        bus.iq_full_i = 1'b0;
        step();
        total++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h40) begin bad++; $display("FAIL rdy_req: got %b %h exp 1 00000040", bus.mem_req_o, bus.mem_addr_o); end
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h40 || bus.iq_we_o !== 1'b0) begin
                bad++; $display("FAIL rdy_hold_req: got req %b addr %h we %b exp 1 00000040 0", bus.mem_req_o, bus.mem_addr_o, bus.iq_we_o);
            end
        end
        rdy = 1'b1;
        step();
        total++; if (bus.mem_req_o !== 1'b0 || bus.iq_we_o !== 1'b0) begin bad++; $display("FAIL rdy_resume: got req %b we %b exp 0 0", bus.mem_req_o, bus.iq_we_o); end
        step(); step();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (bus.mem_req_o !== 1'b0 || bus.iq_we_o !== 1'b0) begin bad++; $display("FAIL rdy_hold_done: got req %b we %b exp 0 0", bus.mem_req_o, bus.iq_we_o); end
        end
        rdy = 1'b1;
        step();
        total++;
        if (bus.iq_we_o !== 1'b1 || bus.iq_pc_o !== 32'h40 || bus.iq_inst_o !== d) begin
            bad++; $display("FAIL rdy_write: got we %b (%h,%h) exp 1 (00000040,%h)", bus.iq_we_o, bus.iq_pc_o, bus.iq_inst_o, d);
        end
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (bus.iq_we_o !== 1'b1 || bus.iq_pc_o !== 32'h40 || bus.iq_inst_o !== d || bus.mem_req_o !== 1'b0) begin
                bad++; $display("FAIL rdy_hold_we: got we %b (%h,%h) req %b exp 1 (00000040,%h) 0", bus.iq_we_o, bus.iq_pc_o, bus.iq_inst_o, bus.mem_req_o, d);
            end
        end
        rdy = 1'b1;
        step();
        total++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h44 || bus.iq_we_o !== 1'b0) begin
            bad++; $display("FAIL rdy_next_req: got req %b addr %h we %b exp 1 00000044 0", bus.mem_req_o, bus.mem_addr_o, bus.iq_we_o);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        fixed_data = 1'b0;
        mem_lat = 2;
        do_reset(1'b1);
        redirect_idle(32'hFFFF_FFFC);
        bus.iq_full_i = 1'b0;
        wait_we(10, ok);
        total++;
        if (!ok || bus.iq_pc_o !== 32'hFFFF_FFFC || bus.iq_inst_o !== mem_word(32'hFFFF_FFFC)) begin
            bad++; $display("FAIL wrap_write: got ok %b (%h,%h) exp (fffffffc,%h)", ok, bus.iq_pc_o, bus.iq_inst_o, mem_word(32'hFFFF_FFFC));
        end
        wait_req(4, ok);
        total++;
        if (!ok || bus.mem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_req: got ok %b addr %h exp 00000000", ok, bus.mem_addr_o); end
    endtask

    // Fetch-stream model: next PC, one outstanding fetch, and whether it was killed
    task automatic test_random();
        logic [31:0] exp_pc, out_addr, e_addr, e_inst, e_pc, p_rpc, p_data;
        bit outst, poison, e_req, e_we, was_idle;
        logic p_rdy, p_redir, p_full, p_done;
        fixed_data = 1'b0;
        mem_lat = 2;
        do_reset(1'b0);
        exp_pc = 32'h0; out_addr = 32'h0; outst = 1'b0; poison = 1'b0;
        e_req = 1'b0; e_addr = 32'h0; e_we = 1'b0; e_inst = 32'h0; e_pc = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            p_rdy = rdy; p_redir = bus.redirect_i; p_rpc = bus.redirect_pc_i; p_full = bus.iq_full_i;
            p_done = bus.mem_done_i; p_data = bus.mem_data_i;
            step();
            if (p_rdy) begin
                was_idle = !outst;
                e_req = 1'b0;
                e_we  = 1'b0;
                if (p_done && outst) begin
                    if (!poison && !p_redir) begin
                        e_we = 1'b1; e_inst = p_data; e_pc = out_addr; exp_pc = out_addr + 32'd4;
                    end
                    outst = 1'b0;
                end
                if (p_redir) begin
                    exp_pc = p_rpc & 32'hFFFF_FFFC;
                    if (outst) poison = 1'b1;
                end
                if (was_idle && !p_redir && !p_full) begin
                    e_req = 1'b1; e_addr = exp_pc; out_addr = exp_pc; outst = 1'b1; poison = 1'b0;
                end
            end
            total++; if (bus.mem_req_o !== e_req) begin bad++; $display("FAIL rnd_req: cyc %0d got %b exp %b", cyc, bus.mem_req_o, e_req); end
            total++; if (bus.mem_addr_o !== e_addr) begin bad++; $display("FAIL rnd_addr: cyc %0d got %h exp %h", cyc, bus.mem_addr_o, e_addr); end
            total++; if (bus.iq_we_o !== e_we) begin bad++; $display("FAIL rnd_we: cyc %0d got %b exp %b", cyc, bus.iq_we_o, e_we); end
            total++; if (bus.iq_inst_o !== e_inst) begin bad++; $display("FAIL rnd_inst: cyc %0d got %h exp %h", cyc, bus.iq_inst_o, e_inst); end
            total++; if (bus.iq_pc_o !== e_pc) begin bad++; $display("FAIL rnd_pc: cyc %0d got %h exp %h", cyc, bus.iq_pc_o, e_pc); end
            rdy               = ($urandom_range(0, 7) != 0);
            bus.redirect_i    = ($urandom_range(0, 11) == 0);
            bus.redirect_pc_i = $urandom;
            bus.iq_full_i     = ($urandom_range(0, 3) == 0);
            mem_lat           = $urandom_range(1, 4);
        end
        rdy = 1'b1;
        bus.redirect_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full();
        test_redirect_drop();
        test_redirect_done();
        test_rdy_freeze();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
